// File: rtl/count_mon_pkg.sv
// Shared types for the counter monitor: FSM state and step classification.
package count_mon_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_UP    = 2'd1,
        S_DOWN  = 2'd2,
        S_STOP  = 2'd3
    } mon_state_t;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_JUMP = 2'd3
    } step_t;

endpackage

// File: rtl/count_monitor_step_classifier.sv
// Combinational classifier of one counter transition (prev -> sample),
// arithmetic modulo 2^NBITS_COUNT. Priority HOLD > UP > DOWN > JUMP.
module step_classifier
    import count_mon_pkg::*;
#(
    parameter int unsigned NBITS_COUNT = 4
) (
    input  logic [NBITS_COUNT-1:0] prev,
    input  logic [NBITS_COUNT-1:0] sample,
    output step_t                  step,
    output logic                   up_wrap,
    output logic                   down_wrap
);

    localparam logic [NBITS_COUNT-1:0] ONE = NBITS_COUNT'(1);

    logic [NBITS_COUNT-1:0] prev_inc;
    logic [NBITS_COUNT-1:0] prev_dec;

    assign prev_inc = prev + ONE;
    assign prev_dec = prev - ONE;

    // Classify the step and flag the wrap cases of an adjacent step
    always_comb begin
        step      = STEP_JUMP;
        up_wrap   = 1'b0;
        down_wrap = 1'b0;
        if (sample == prev) begin
            step = STEP_HOLD;
        end else if (sample == prev_inc) begin
            step    = STEP_UP;
            up_wrap = (prev == '1);
        end else if (sample == prev_dec) begin
            step      = STEP_DOWN;
            down_wrap = (prev == '0);
        end
    end

endmodule

// File: rtl/count_monitor.sv
// Observer for the mod-2^N lab-board counter: classifies each accepted
// sample, tracks direction/stall and keeps a net wrap count.
// Optional macro MONITOR_ERR_EN adds err_clr/err_sticky (load during counting).
module count_monitor
    import count_mon_pkg::*;
#(
    parameter int unsigned NBITS_COUNT = 4,
    parameter int unsigned NBITS_WRAP  = 4,
    parameter int unsigned STALL_LIMIT = 8
) (
    input  logic                   clk_2,
    input  logic                   reset,
    input  logic                   sample_valid,
    input  logic [NBITS_COUNT-1:0] sample,
`ifdef MONITOR_ERR_EN
    input  logic                   err_clr,
    output logic                   err_sticky,
`endif
    output logic [1:0]             state,
    output logic                   dir_up,
    output logic                   dir_down,
    output logic                   stopped,
    output logic                   jump,
    output logic                   wrap_pulse,
    output logic [NBITS_WRAP-1:0]  wrap_count,
    output logic [NBITS_COUNT-1:0] last_sample
);

    localparam int unsigned HW = $clog2(STALL_LIMIT + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(STALL_LIMIT);
    localparam logic [NBITS_WRAP-1:0] WONE = NBITS_WRAP'(1);

    mon_state_t             state_q, state_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic                   jump_d, wrap_d;
    logic [NBITS_WRAP-1:0]  wcnt_d;
    step_t                  step;
    logic                   up_wrap, down_wrap;

    step_classifier #(
        .NBITS_COUNT (NBITS_COUNT)
    ) u_classifier (
        .prev      (last_sample),
        .sample    (sample),
        .step      (step),
        .up_wrap   (up_wrap),
        .down_wrap (down_wrap)
    );

    assign state = state_q;

    // Next-state, hold counter, pulses and wrap count for an accepted sample
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        jump_d  = 1'b0;
        wrap_d  = 1'b0;
        wcnt_d  = wrap_count;
        if (sample_valid) begin
            if (state_q == S_EMPTY) begin
                state_d = S_STOP;
            end else begin
                unique case (step)
                    STEP_HOLD: begin
                        if (hold_q < HOLD_MAX) hold_d = hold_q + HW'(1);
                        if (hold_d >= HOLD_MAX) state_d = S_STOP;
                    end
                    STEP_UP: begin
                        state_d = S_UP;
                        hold_d  = '0;
                        if (up_wrap) begin
                            wrap_d = 1'b1;
                            wcnt_d = wrap_count + WONE;
                        end
                    end
                    STEP_DOWN: begin
                        state_d = S_DOWN;
                        hold_d  = '0;
                        if (down_wrap) begin
                            wrap_d = 1'b1;
                            wcnt_d = wrap_count - WONE;
                        end
                    end
                    default: begin
                        state_d = S_STOP;
                        jump_d  = 1'b1;
                        hold_d  = '0;
                    end
                endcase
            end
        end
    end

    // Register state and all outputs; direction flags decode the next state
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            hold_q      <= '0;
            dir_up      <= 1'b0;
            dir_down    <= 1'b0;
            stopped     <= 1'b0;
            jump        <= 1'b0;
            wrap_pulse  <= 1'b0;
            wrap_count  <= '0;
            last_sample <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            dir_up     <= (state_d == S_UP);
            dir_down   <= (state_d == S_DOWN);
            stopped    <= (state_d == S_STOP);
            jump       <= jump_d;
            wrap_pulse <= wrap_d;
            wrap_count <= wcnt_d;
            if (sample_valid) last_sample <= sample;
        end
    end

`ifdef MONITOR_ERR_EN
    // Sticky flag for a load seen while actively counting; set beats clear
    always_ff @(posedge clk_2) begin
        if (reset) begin
            err_sticky <= 1'b0;
        end else if (sample_valid && step == STEP_JUMP &&
                     (state_q == S_UP || state_q == S_DOWN)) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Directed, table-driven bench for count_monitor (default parameters).
module tb_count_monitor;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic       sample_valid;
    logic [3:0] sample;
    logic [1:0] state;
    logic       dir_up, dir_down, stopped, jump, wrap_pulse;
    logic [3:0] wrap_count, last_sample;
`ifdef MONITOR_ERR_EN
    logic       err_clr;
    logic       err_sticky;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_2 = ~clk_2;

    count_monitor #(
        .NBITS_COUNT (4),
        .NBITS_WRAP  (4),
        .STALL_LIMIT (8)
    ) dut (
        .clk_2        (clk_2),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
`ifdef MONITOR_ERR_EN
        .err_clr      (err_clr),
        .err_sticky   (err_sticky),
`endif
        .state        (state),
        .dir_up       (dir_up),
        .dir_down     (dir_down),
        .stopped      (stopped),
        .jump         (jump),
        .wrap_pulse   (wrap_pulse),
        .wrap_count   (wrap_count),
        .last_sample  (last_sample)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [3:0] smp;
        logic [1:0] st;
        logic       jmp;
        logic       wp;
        logic [3:0] wc;
        logic [3:0] last;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] s);
        reset        = r;
        sample_valid = v;
        sample       = s;
        @(posedge clk_2);
        #1;
    endtask

    task automatic check_state(input string name, input int idx, input logic [1:0] st);
        check({name, ".state"}, idx, 32'(state), 32'(st));
        check({name, ".dir_up"}, idx, 32'(dir_up), 32'(st == 2'd1));
        check({name, ".dir_down"}, idx, 32'(dir_down), 32'(st == 2'd2));
        check({name, ".stopped"}, idx, 32'(stopped), 32'(st == 2'd3));
    endtask

    function automatic vec_t v(input logic r, input logic vl, input logic [3:0] s,
                               input logic [1:0] st, input logic j, input logic w,
                               input logic [3:0] wc, input logic [3:0] l);
        vec_t x;
        x.rst = r; x.vld = vl; x.smp = s; x.st = st;
        x.jmp = j; x.wp = w; x.wc = wc; x.last = l;
        return x;
    endfunction

    initial begin
        // states: 0 EMPTY, 1 UP, 2 DOWN, 3 STOP
        //          rst vld smp  st  jmp wp  wc    last
        vecs.push_back(v(1, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0)); // reset
        vecs.push_back(v(0, 1, 4'h3, 3, 0, 0, 4'h0, 4'h3)); // first sample -> STOP
        vecs.push_back(v(0, 1, 4'h4, 1, 0, 0, 4'h0, 4'h4));
        vecs.push_back(v(0, 1, 4'h5, 1, 0, 0, 4'h0, 4'h5));
        vecs.push_back(v(0, 1, 4'hE, 3, 1, 0, 4'h0, 4'hE)); // load
        vecs.push_back(v(0, 1, 4'hF, 1, 0, 0, 4'h0, 4'hF));
        vecs.push_back(v(0, 1, 4'h0, 1, 0, 1, 4'h1, 4'h0)); // up-wrap
        vecs.push_back(v(0, 1, 4'h1, 1, 0, 0, 4'h1, 4'h1));
        vecs.push_back(v(0, 0, 4'h7, 1, 0, 0, 4'h1, 4'h1)); // idle: all holds
        vecs.push_back(v(1, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0)); // reset
        vecs.push_back(v(0, 1, 4'h1, 3, 0, 0, 4'h0, 4'h1));
        vecs.push_back(v(0, 1, 4'h0, 2, 0, 0, 4'h0, 4'h0));
        vecs.push_back(v(0, 1, 4'hF, 2, 0, 1, 4'hF, 4'hF)); // down-wrap, wc 0 -> F
        vecs.push_back(v(0, 1, 4'hE, 2, 0, 0, 4'hF, 4'hE));
        vecs.push_back(v(0, 1, 4'h2, 3, 1, 0, 4'hF, 4'h2)); // load
        vecs.push_back(v(0, 1, 4'h3, 1, 0, 0, 4'hF, 4'h3));
        vecs.push_back(v(0, 1, 4'h9, 3, 1, 0, 4'hF, 4'h9)); // load
        vecs.push_back(v(0, 1, 4'h9, 3, 0, 0, 4'hF, 4'h9)); // jump pulse gone
        vecs.push_back(v(0, 1, 4'hA, 1, 0, 0, 4'hF, 4'hA));
        vecs.push_back(v(1, 1, 4'h5, 0, 0, 0, 4'h0, 4'h0)); // reset beats valid
        vecs.push_back(v(0, 0, 4'h5, 0, 0, 0, 4'h0, 4'h0)); // EMPTY holds w/o valid
        vecs.push_back(v(0, 1, 4'hF, 3, 0, 0, 4'h0, 4'hF)); // first sample no wrap

        reset = 1'b1; sample_valid = 1'b0; sample = '0;
`ifdef MONITOR_ERR_EN
        err_clr = 1'b0;
`endif
        @(negedge clk_2);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].vld, vecs[i].smp);
            check_state("vec", i, vecs[i].st);
            check("vec.jump", i, 32'(jump), 32'(vecs[i].jmp));
            check("vec.wrap_pulse", i, 32'(wrap_pulse), 32'(vecs[i].wp));
            check("vec.wrap_count", i, 32'(wrap_count), 32'(vecs[i].wc));
            check("vec.last_sample", i, 32'(last_sample), 32'(vecs[i].last));
        end

        // Stall: 7 holds keep UP, the 8th declares STOP, next step resumes UP
        step(1, 0, 4'h0);
        step(0, 1, 4'h6);
        step(0, 1, 4'h7);
        check_state("stall.pre", 0, 2'd1);
        for (int k = 1; k <= 7; k++) begin
            step(0, 1, 4'h7);
            check_state("stall.hold", k, 2'd1);
        end
        step(0, 1, 4'h7);
        check_state("stall.limit", 8, 2'd3);
        step(0, 1, 4'h7);
        check_state("stall.sat", 9, 2'd3);
        step(0, 1, 4'h8);
        check_state("stall.resume", 0, 2'd1);

        // Hold counter is cleared by a step: 7 holds in DOWN, one step, 7 more
        step(0, 1, 4'h7);
        for (int k = 1; k <= 7; k++) step(0, 1, 4'h7);
        check_state("stall.down7", 0, 2'd2);
        step(0, 1, 4'h6);
        for (int k = 1; k <= 7; k++) step(0, 1, 4'h6);
        check_state("stall.clr", 0, 2'd2);
        step(0, 0, 4'h6);
        check_state("stall.idle", 0, 2'd2);
        step(0, 1, 4'h6);
        check_state("stall.down8", 0, 2'd3);

`ifdef MONITOR_ERR_EN
        step(1, 0, 4'h0);
        check("err.reset", 0, 32'(err_sticky), 32'd0);
        step(0, 1, 4'h2);
        step(0, 1, 4'h3);
        step(0, 1, 4'h9);
        check("err.set", 0, 32'(err_sticky), 32'd1);
        step(0, 1, 4'h3);          // jump from STOP: no effect
        step(0, 0, 4'h3);
        check("err.hold", 0, 32'(err_sticky), 32'd1);
        err_clr = 1'b1;
        step(0, 0, 4'h3);
        err_clr = 1'b0;
        check("err.clr", 0, 32'(err_sticky), 32'd0);
        step(0, 1, 4'hB);          // jump from STOP does not set
        check("err.stop_jump", 0, 32'(err_sticky), 32'd0);
        step(0, 1, 4'hC);
        err_clr = 1'b1;
        step(0, 1, 4'h1);          // jump from UP with clear: set wins
        err_clr = 1'b0;
        check("err.set_wins", 0, 32'(err_sticky), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
